// File: rtl/lcd_screen_ctrl.sv
// lcd_screen_ctrl
// Screen sequencer above the 4-bit LCD communication block. It keeps a
// 32-character shadow buffer for a 2x16 HD44780-style display. After the
// communication block finishes power-on, it sends the controller init
// commands. It then redraws the whole screen whenever the buffer has changed
// or a refresh is requested.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   buf_we/addr/wdata     host character write (0-15 line 1, 16-31 line 2)
//   refresh               force a full redraw
//   ready                 high while idle
//   frame_done            one-cycle pulse when a redraw completes
//   lcd_start/data/write/system, lcd_busy   byte handshake to the comm block
module lcd_screen_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       buf_we,
    input  logic [4:0] buf_addr,
    input  logic [7:0] buf_wdata,
    input  logic       refresh,
    output logic       ready,
    output logic       frame_done,
    output logic       lcd_start,
    output logic [7:0] lcd_data,
    output logic       lcd_write,
    output logic       lcd_system,
    input  logic       lcd_busy
);

    localparam logic [7:0] DISP_CTRL  = 8'h0C;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] FUNC_SET   = 8'h28;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] SPACE      = 8'h20;

    typedef enum logic [2:0] {
        S_BOOT, S_INIT, S_IDLE, S_ADDR, S_CHAR, S_WAIT
    } state_t;

    state_t          state, state_nx, ret, ret_nx;
    logic [1:0]      idx, idx_nx;
    logic            line, line_nx;
    logic [3:0]      col, col_nx;
    logic [31:0][7:0] buffer;
    logic            dirty;

    logic            issue, issue_sys, clr_dirty, frame_end;
    logic [7:0]      issue_data, init_cmd;

    assign lcd_write = 1'b1;

    always_comb begin
        case (idx)
            2'd0:    init_cmd = FUNC_SET;
            2'd1:    init_cmd = DISP_CTRL;
            2'd2:    init_cmd = ENTRY_MODE;
            default: init_cmd = CLEAR;
        endcase
    end

    always_comb begin
        state_nx   = state;
        ret_nx     = ret;
        idx_nx     = idx;
        line_nx    = line;
        col_nx     = col;
        issue      = 1'b0;
        issue_data = 8'h00;
        issue_sys  = 1'b1;
        clr_dirty  = 1'b0;
        frame_end  = 1'b0;
        case (state)
            S_BOOT: begin
                if (!lcd_busy) begin
                    state_nx = S_INIT;
                    idx_nx   = 2'd0;
                end
            end
            S_INIT: begin
                issue      = 1'b1;
                issue_data = init_cmd;
                state_nx   = S_WAIT;
                ret_nx     = (idx == 2'd3) ? S_IDLE : S_INIT;
                idx_nx     = idx + 2'd1;
            end
            S_IDLE: begin
                if (dirty) begin
                    state_nx  = S_ADDR;
                    line_nx   = 1'b0;
                    col_nx    = 4'd0;
                    clr_dirty = 1'b1;
                end
            end
            S_ADDR: begin
                issue      = 1'b1;
                issue_data = line ? 8'hC0 : 8'h80;
                state_nx   = S_WAIT;
                ret_nx     = S_CHAR;
            end
            S_CHAR: begin
                issue      = 1'b1;
                issue_data = buffer[{line, col}];
                issue_sys  = 1'b0;
                state_nx   = S_WAIT;
                // Position advances at issue time; the next read happens at
                // the next issue, so the current byte is unaffected.
                if (col != 4'd15) begin
                    col_nx = col + 4'd1;
                    ret_nx = S_CHAR;
                end else if (!line) begin
                    line_nx = 1'b1;
                    col_nx  = 4'd0;
                    ret_nx  = S_ADDR;
                end else begin
                    ret_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                // lcd_start is high exactly in the first wait cycle, when
                // busy is only an echo of our own strobe.
                if (!lcd_start && !lcd_busy) begin
                    state_nx = ret;
                    // line stays 1 only after the final character of a frame;
                    // init returns to idle with line = 0.
                    frame_end = (ret == S_IDLE) && line;
                end
            end
            default: state_nx = S_BOOT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_BOOT;
            ret        <= S_IDLE;
            idx        <= 2'd0;
            line       <= 1'b0;
            col        <= 4'd0;
            buffer     <= {32{SPACE}};
            dirty      <= 1'b1;
            lcd_start  <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_system <= 1'b1;
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            ret        <= ret_nx;
            idx        <= idx_nx;
            line       <= line_nx;
            col        <= col_nx;
            lcd_start  <= issue;
            ready      <= (state_nx == S_IDLE);
            frame_done <= frame_end;
            if (issue) begin
                lcd_data   <= issue_data;
                lcd_system <= issue_sys;
            end
            if (buf_we)
                buffer[buf_addr] <= buf_wdata;
            // A new write or refresh beats the clear on redraw start.
            if (buf_we || refresh)
                dirty <= 1'b1;
            else if (clr_dirty)
                dirty <= 1'b0;
        end
    end

endmodule
